// File: rtl/cpu_run_ctrl.sv
// Run controller for a single-cycle RV32I core: sequences core reset, counts cycles and
// retirements, and stops the run on ebreak, ecall, a jump-to-self loop or a timeout.
module cpu_run_ctrl #(
  parameter int XLEN       = 32,
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 85,
  parameter int LOOP_LIMIT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [XLEN-1:0]  pc,
  input  logic [31:0]      inst,
  input  logic             inst_valid,
  output logic             core_rst,
  output logic             busy,
  output logic             done,
  output logic [2:0]       halt_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;

  localparam logic [31:0]      EBREAK     = 32'h00100073;
  localparam logic [31:0]      ECALL      = 32'h00000073;
  localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(MAX_CYCLES - 1);
  localparam logic [7:0]       RST_LAST   = 8'(RST_CYCLES - 1);
  localparam logic [3:0]       LOOP_LAST  = 4'(LOOP_LIMIT - 1);

  localparam logic [2:0] HC_NONE    = 3'd0;
  localparam logic [2:0] HC_EBREAK  = 3'd1;
  localparam logic [2:0] HC_ECALL   = 3'd2;
  localparam logic [2:0] HC_LOOP    = 3'd3;
  localparam logic [2:0] HC_TIMEOUT = 3'd4;

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        rst_cnt;
  logic [3:0]        loop_cnt;
  logic [XLEN-1:0]   last_pc;
  logic              last_vld;
  logic              pc_match;
  logic              clear;
  logic [2:0]        halt_nxt;

  always_comb begin
    state_nxt = state;
    halt_nxt  = HC_NONE;
    clear     = 1'b0;
    pc_match  = inst_valid && last_vld && (pc == last_pc);
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RESET;
          clear     = 1'b1;
        end
      end
      RESET: begin
        if (rst_cnt == RST_LAST) state_nxt = RUN;
      end
      RUN: begin
        // Priority order matters: an ecall at a looping PC still reports as ecall.
        if (inst_valid && inst == EBREAK)          halt_nxt = HC_EBREAK;
        else if (inst_valid && inst == ECALL)      halt_nxt = HC_ECALL;
        else if (pc_match && loop_cnt == LOOP_LAST) halt_nxt = HC_LOOP;
        else if (cycle_cnt == TIMEOUT_AT)          halt_nxt = HC_TIMEOUT;
        if (halt_nxt != HC_NONE) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are flops loaded from the next state so nothing is combinational from inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      core_rst <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      core_rst <= (state_nxt != RUN);
      busy     <= (state_nxt == RESET) || (state_nxt == RUN);
      done     <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_cnt   <= '0;
      loop_cnt  <= '0;
      last_pc   <= '0;
      last_vld  <= 1'b0;
      cycle_cnt <= '0;
      instret   <= '0;
      halt_code <= HC_NONE;
    end else if (clear) begin
      rst_cnt   <= '0;
      loop_cnt  <= '0;
      last_pc   <= '0;
      last_vld  <= 1'b0;
      cycle_cnt <= '0;
      instret   <= '0;
      halt_code <= HC_NONE;
    end else begin
      if (state == RESET) rst_cnt <= rst_cnt + 8'd1;
      if (state == RUN) begin
        if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
        if (inst_valid) begin
          if (instret != '1) instret <= instret + 1'b1;
          last_pc  <= pc;
          last_vld <= 1'b1;
          loop_cnt <= pc_match ? loop_cnt + 4'd1 : 4'd0;
        end
        if (halt_nxt != HC_NONE) halt_code <= halt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: default instance plus a narrow-counter instance.
module tb_cpu_run_ctrl;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] ECALL  = 32'h00000073;

  typedef struct packed {
    logic [2:0]  code;
    logic [15:0] cyc;
    logic [15:0] ret;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start = 1'b0;
  logic        start_s = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] inst = '0;
  logic        inst_valid = 1'b0;

  logic        core_rst, busy, done;
  logic [2:0]  halt_code;
  logic [15:0] cycle_cnt, instret;
  logic        core_rst_s, busy_s, done_s;
  logic [2:0]  halt_code_s;
  logic [3:0]  cycle_cnt_s, instret_s;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   passed = 0;
  int   n;
  logic seen_done;

  cpu_run_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .inst(inst), .inst_valid(inst_valid),
    .core_rst(core_rst), .busy(busy), .done(done), .halt_code(halt_code),
    .cycle_cnt(cycle_cnt), .instret(instret)
  );

  cpu_run_ctrl #(.CNT_W(4), .MAX_CYCLES(15)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .pc(pc), .inst(inst), .inst_valid(inst_valid),
    .core_rst(core_rst_s), .busy(busy_s), .done(done_s), .halt_code(halt_code_s),
    .cycle_cnt(cycle_cnt_s), .instret(instret_s)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] p, input logic [31:0] i);
    pc = p; inst = i; inst_valid = 1'b1;
    step();
    inst_valid = 1'b0;
  endtask

  task automatic bubble();
    inst_valid = 1'b0;
    step();
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({core_rst, busy, done, halt_code, cycle_cnt, instret} !== {1'b1, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0})
      $display("FAIL reset_values: core_rst=%b busy=%b done=%b code=%0d cyc=%0d ret=%0d", core_rst, busy, done, halt_code, cycle_cnt, instret);
    else passed++;
    step(); step();
    @(negedge clk) rst = 1'b1;
    step();
  endtask

  task automatic test_start();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({busy, core_rst, done} !== 3'b110) $display("FAIL start_reset1: busy=%b core_rst=%b done=%b want 1 1 0", busy, core_rst, done);
    else passed++;
    step();
    checks++;
    if ({busy, core_rst} !== 2'b11) $display("FAIL start_reset2: busy=%b core_rst=%b want 1 1", busy, core_rst);
    else passed++;
    step();
    checks++;
    if ({busy, core_rst, cycle_cnt} !== {2'b10, 16'd0}) $display("FAIL start_run: busy=%b core_rst=%b cyc=%0d want 1 0 0", busy, core_rst, cycle_cnt);
    else passed++;
  endtask

  // Continues from the first RUN cycle left by test_start.
  task automatic test_ebreak();
    for (int k = 0; k < 5; k++) retire(32'(k * 4), NOP);
    sb.push_back('{code: 3'd1, cyc: 16'd6, ret: 16'd6});
    retire(32'd20, EBREAK);
    checks++;
    if ({done, busy, core_rst} !== 3'b101) $display("FAIL ebreak_next_cycle: done=%b busy=%b core_rst=%b want 1 0 1", done, busy, core_rst);
    else passed++;
    e = sb.pop_front();
    checks++;
    if ({halt_code, cycle_cnt, instret} !== {e.code, e.cyc, e.ret})
      $display("FAIL ebreak_report: got code=%0d cyc=%0d ret=%0d want code=%0d cyc=%0d ret=%0d", halt_code, cycle_cnt, instret, e.code, e.cyc, e.ret);
    else passed++;
  endtask

  task automatic test_self_loop();
    start_run();
    sb.push_back('{code: 3'd3, cyc: 16'd9, ret: 16'd5});
    retire(32'h40, NOP); bubble();
    retire(32'h40, NOP); bubble(); bubble();
    retire(32'h40, NOP); retire(32'h40, NOP); bubble();
    checks++;
    if (done !== 1'b0) $display("FAIL loop_early: done=%b after 4 retirements want 0", done);
    else passed++;
    retire(32'h40, NOP);
    n = 0;
    while (done !== 1'b1 && n < 50) begin step(); n++; end
    checks++;
    if (done !== 1'b1) $display("FAIL loop_wait: done=%b want 1 within 50 cycles", done);
    else passed++;
    e = sb.pop_front();
    checks++;
    if ({halt_code, cycle_cnt, instret} !== {e.code, e.cyc, e.ret})
      $display("FAIL loop_report: got code=%0d cyc=%0d ret=%0d want code=%0d cyc=%0d ret=%0d", halt_code, cycle_cnt, instret, e.code, e.cyc, e.ret);
    else passed++;
  endtask

  task automatic test_priority();
    start_run();
    sb.push_back('{code: 3'd2, cyc: 16'd8, ret: 16'd8});
    for (int k = 0; k < 3; k++) retire(32'h80, NOP);
    for (int k = 0; k < 4; k++) retire(32'h84, NOP);
    retire(32'h84, ECALL);
    n = 0;
    while (done !== 1'b1 && n < 50) begin step(); n++; end
    checks++;
    if (done !== 1'b1) $display("FAIL prio_wait: done=%b want 1 within 50 cycles", done);
    else passed++;
    e = sb.pop_front();
    checks++;
    if ({halt_code, cycle_cnt, instret} !== {e.code, e.cyc, e.ret})
      $display("FAIL prio_report: got code=%0d cyc=%0d ret=%0d want code=%0d cyc=%0d ret=%0d", halt_code, cycle_cnt, instret, e.code, e.cyc, e.ret);
    else passed++;
  endtask

  task automatic test_timeout();
    start_run();
    sb.push_back('{code: 3'd4, cyc: 16'd85, ret: 16'd85});
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      retire(32'h1000 + 32'(n * 4), NOP);
      n++;
    end
    checks++;
    if (n !== 85) $display("FAIL timeout_cycles: done after %0d run cycles want 85", n);
    else passed++;
    e = sb.pop_front();
    checks++;
    if ({halt_code, cycle_cnt, instret} !== {e.code, e.cyc, e.ret})
      $display("FAIL timeout_report: got code=%0d cyc=%0d ret=%0d want code=%0d cyc=%0d ret=%0d", halt_code, cycle_cnt, instret, e.code, e.cyc, e.ret);
    else passed++;
    step(); step();
    checks++;
    if ({done, halt_code, cycle_cnt} !== {1'b1, 3'd4, 16'd85}) $display("FAIL done_hold: done=%b code=%0d cyc=%0d want 1 4 85", done, halt_code, cycle_cnt);
    else passed++;
  endtask

  task automatic test_restart();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({busy, done, core_rst, halt_code, cycle_cnt, instret} !== {3'b101, 3'd0, 16'd0, 16'd0})
      $display("FAIL restart_clear: busy=%b done=%b core_rst=%b code=%0d cyc=%0d ret=%0d", busy, done, core_rst, halt_code, cycle_cnt, instret);
    else passed++;
    step();
    checks++;
    if (core_rst !== 1'b1) $display("FAIL restart_reset2: core_rst=%b want 1", core_rst);
    else passed++;
    step();
    checks++;
    if (core_rst !== 1'b0) $display("FAIL restart_run: core_rst=%b want 0", core_rst);
    else passed++;
    retire(32'h200, NOP); retire(32'h204, NOP); bubble();
    checks++;
    if ({cycle_cnt, instret} !== {16'd3, 16'd2}) $display("FAIL restart_count: cyc=%0d ret=%0d want 3 2", cycle_cnt, instret);
    else passed++;
  endtask

  task automatic test_abort();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({core_rst, busy, done, halt_code, cycle_cnt, instret} !== {1'b1, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0})
      $display("FAIL abort_values: core_rst=%b busy=%b done=%b code=%0d cyc=%0d ret=%0d", core_rst, busy, done, halt_code, cycle_cnt, instret);
    else passed++;
    seen_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      retire(32'h300, EBREAK);
      if (done === 1'b1) seen_done = 1'b1;
    end
    @(negedge clk) rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      retire(32'h300, EBREAK);
      if (done === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if ({seen_done, busy} !== 2'b00) $display("FAIL abort_no_done: seen_done=%b busy=%b want 0 0", seen_done, busy);
    else passed++;
  endtask

  task automatic test_saturation();
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    step(); step();
    sb.push_back('{code: 3'd4, cyc: 16'd15, ret: 16'd15});
    n = 0;
    while (done_s !== 1'b1 && n < 100) begin
      retire(32'h2000 + 32'(n * 4), NOP);
      n++;
    end
    checks++;
    if (n !== 15) $display("FAIL sat_cycles: done after %0d run cycles want 15", n);
    else passed++;
    e = sb.pop_front();
    checks++;
    if ({halt_code_s, 16'(cycle_cnt_s), 16'(instret_s)} !== {e.code, e.cyc, e.ret})
      $display("FAIL sat_report: got code=%0d cyc=%0d ret=%0d want code=%0d cyc=%0d ret=%0d", halt_code_s, cycle_cnt_s, instret_s, e.code, e.cyc, e.ret);
    else passed++;
    for (int k = 0; k < 3; k++) retire(32'h3000, NOP);
    checks++;
    if ({done_s, cycle_cnt_s, instret_s} !== {1'b1, 4'hF, 4'hF}) $display("FAIL sat_hold: done=%b cyc=%0d ret=%0d want 1 15 15", done_s, cycle_cnt_s, instret_s);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_start();
    test_ebreak();
    test_self_loop();
    test_priority();
    test_timeout();
    test_restart();
    test_abort();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
